// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS memory path.
// Used by the memory access sequencer and its counter.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_HOLD,
    RESP
  } mau_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              instr;
  } mau_req_t;

  function automatic logic is_misaligned(
    input logic [ADDR_W-1:0] a
  );
    return (a[1:0] & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mau_counter.sv
// Loadable down-counter with zero flag.
// Times both the read latency and the store hold.
module mau_counter #(
  parameter int W = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         load,
  input  logic [W-1:0] init,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= init;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access sequencer: one load/store at a time to a
// synchronous word memory, with IR/MDR capture and done pulse.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int WR_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_instr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              rsp_done,
  output logic              rsp_err,
  output logic              err_sticky,
  output logic [WORD_W-1:0] ir_q,
  output logic [WORD_W-1:0] mdr_q
);

  mau_state_t state;
  mau_req_t   req_q;

  logic       cnt_zero;
  logic       cnt_load;
  logic       cnt_dec;
  logic [2:0] cnt_init;
  logic       accept;

  assign accept   = (state == IDLE) && req_valid;
  assign cnt_load = accept && !is_misaligned(req_addr);
  assign cnt_init = req_wr ? 3'(WR_CYC - 1) : 3'(RD_LAT - 1);
  assign cnt_dec  = ((state == READ_WAIT) ||
                     (state == WRITE_HOLD)) && !cnt_zero;

  mau_counter #(
    .W(3)
  ) u_cnt (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .load   (cnt_load),
    .init   (cnt_init),
    .dec    (cnt_dec),
    .zero   (cnt_zero)
  );

  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      mem_wr     <= 1'b0;
      rsp_done   <= 1'b0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
      ir_q       <= '0;
      mdr_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= '{addr:  req_addr,
                       wdata: req_wdata,
                       instr: req_instr};
            req_ready <= 1'b0;
            if (is_misaligned(req_addr)) begin
              state      <= RESP;
              rsp_done   <= 1'b1;
              rsp_err    <= 1'b1;
              err_sticky <= 1'b1;
            end else if (req_wr) begin
              state  <= WRITE_HOLD;
              mem_wr <= 1'b1;
            end else begin
              state <= READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (cnt_zero) begin
            if (req_q.instr) ir_q <= mem_rdata;
            else             mdr_q <= mem_rdata;
            state    <= RESP;
            rsp_done <= 1'b1;
          end
        end
        WRITE_HOLD: begin
          if (cnt_zero) begin
            mem_wr   <= 1'b0;
            state    <= RESP;
            rsp_done <= 1'b1;
          end
        end
        RESP: begin
          rsp_done  <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a
// one-cycle synchronous word memory model.
module tb_mem_access_unit;

  localparam int RD_LAT = 2;
  localparam int WR_CYC = 2;

  logic        Clk;
  logic        Reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_instr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        rsp_done;
  logic        rsp_err;
  logic        err_sticky;
  logic [31:0] ir_q;
  logic [31:0] mdr_q;

  mem_access_unit #(
    .RD_LAT(RD_LAT),
    .WR_CYC(WR_CYC)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_instr (req_instr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .rsp_done  (rsp_done),
    .rsp_err   (rsp_err),
    .err_sticky(err_sticky),
    .ir_q      (ir_q),
    .mdr_q     (mdr_q)
  );

  typedef struct {
    logic        err;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ir;
    logic [31:0] mdr;
    int          lat;
    int          nwr;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          wr_run   = 0;
  int          ndone    = 0;
  int          nexp     = 0;
  logic [31:0] ir_m     = '0;
  logic [31:0] mdr_m    = '0;
  logic [31:0] mem [0:63];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[1]  = 32'h8C22_0010;
    mem[16] = 32'h0000_0000;
  end

  always @(posedge Clk) begin
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge Clk) begin
    if (Reset_n && req_valid && req_ready) acc_q.push_back(cyc);
  end

  always @(negedge Clk) begin
    if (!Reset_n) begin
      wr_run = 0;
    end else begin
      if (mem_wr) begin
        wr_run++;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 32'(mem_wr), 32'd0);
        end else begin
          chk("wr_on_store", 32'(exp_q[0].wr), 32'd1);
          chk("wr_addr", mem_addr, exp_q[0].addr);
          chk("wr_data", mem_wdata, exp_q[0].wdata);
        end
      end
      if (rsp_done) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("done_unexpected", 32'(rsp_done), 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          ndone++;
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("latency", 32'(cyc - a), 32'(e.lat + 1));
          chk("wr_cycles", 32'(wr_run), 32'(e.nwr));
          chk("ir_q", ir_q, e.ir);
          chk("mdr_q", mdr_q, e.mdr);
        end
        wr_run = 0;
      end
    end
  end

  function automatic exp_t ld(input logic [31:0] a,
                              input logic i,
                              input logic [31:0] d);
    exp_t e;
    if (i) ir_m = d;
    else   mdr_m = d;
    e = '{err: 1'b0, wr: 1'b0, addr: a, wdata: 32'h0,
          ir: ir_m, mdr: mdr_m, lat: RD_LAT, nwr: 0};
    return e;
  endfunction

  function automatic exp_t st(input logic [31:0] a,
                              input logic [31:0] d);
    exp_t e;
    e = '{err: 1'b0, wr: 1'b1, addr: a, wdata: d,
          ir: ir_m, mdr: mdr_m, lat: WR_CYC, nwr: WR_CYC};
    return e;
  endfunction

  function automatic exp_t mis(input logic [31:0] a);
    exp_t e;
    e = '{err: 1'b1, wr: 1'b0, addr: a, wdata: 32'h0,
          ir: ir_m, mdr: mdr_m, lat: 0, nwr: 0};
    return e;
  endfunction

  task automatic issue(input logic wr,
                       input logic instr,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input exp_t e);
    int n;
    req_wr    = wr;
    req_instr = instr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    exp_q.push_back(e);
    nexp++;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_instr = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge Clk);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_done", 32'(rsp_done), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ir", ir_q, 32'h0);
    chk("rst_mdr", mdr_q, 32'h0);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    issue(1'b0, 1'b1, 32'h0000_0004, 32'h0,
          ld(32'h0000_0004, 1'b1, 32'h8C22_0010));
    drain();
    chk("ready_after_fetch", 32'(req_ready), 32'd1);

    issue(1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF,
          st(32'h0000_0040, 32'hDEAD_BEEF));
    drain();
    chk("ready_after_store", 32'(req_ready), 32'd1);

    issue(1'b0, 1'b0, 32'h0000_0040, 32'h0,
          ld(32'h0000_0040, 1'b0, 32'hDEAD_BEEF));
    drain();

    issue(1'b0, 1'b0, 32'h0000_0042, 32'h0,
          mis(32'h0000_0042));
    drain();
    chk("sticky_set", 32'(err_sticky), 32'd1);
    issue(1'b0, 1'b0, 32'h0000_0008, 32'h0,
          ld(32'h0000_0008, 1'b0, 32'hA500_0002));
    drain();
    chk("sticky_hold", 32'(err_sticky), 32'd1);

    issue(1'b0, 1'b0, 32'h0000_0004, 32'h0,
          ld(32'h0000_0004, 1'b0, 32'h8C22_0010));
    issue(1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678,
          st(32'h0000_0044, 32'h1234_5678));
    issue(1'b0, 1'b1, 32'h0000_0044, 32'h0,
          ld(32'h0000_0044, 1'b1, 32'h1234_5678));
    drain();
    chk("b2b_count", 32'(ndone), 32'(nexp));

    issue(1'b1, 1'b0, 32'h0000_0048, 32'hCAFE_F00D,
          st(32'h0000_0048, 32'hCAFE_F00D));
    chk("mid_wr_high", 32'(mem_wr), 32'd1);
    req_valid = 1'b0;
    Reset_n   = 1'b0;
    #1;
    chk("mid_wr_drop", 32'(mem_wr), 32'd0);
    chk("mid_done_low", 32'(rsp_done), 32'd0);
    exp_q.delete();
    acc_q.delete();
    nexp--;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_sticky", 32'(err_sticky), 32'd0);
    chk("post_rst_ir", ir_q, 32'h0);
    chk("final_count", 32'(ndone), 32'(nexp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
